// File: rtl/rf_pkg.sv
// Shared constants, FSM state type and data pattern
// for the register-file built-in self-test.
package rf_pkg;

  localparam int NREG = 32;
  localparam int AW   = 5;
  localparam int DW   = 32;
  localparam int CW   = AW + 2;
  localparam int SEED = 100;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WRITE,
    S_READ,
    S_DONE
  } state_e;

  function automatic logic [DW-1:0] pat(
    input logic [AW-1:0] i,
    input logic          psel
  );
    logic [DW-1:0] s;
    s = DW'(SEED) + DW'(i);
    return psel ? ~s : s;
  endfunction

  // x0 reads back as zero whatever was written
  function automatic logic [DW-1:0] exp_val(
    input logic [AW-1:0] i,
    input logic          psel
  );
    return (i == '0) ? '0 : pat(i, psel);
  endfunction

endpackage

// File: rtl/rf_bist_cmp.sv
// Two-port read-back compare: mismatch count and
// first failing index, port 1 taking priority.
module rf_bist_cmp
  import rf_pkg::*;
(
  input  logic [AW-1:0] rs1,
  input  logic [AW-1:0] rs2,
  input  logic          psel,
  input  logic [DW-1:0] rv1,
  input  logic [DW-1:0] rv2,
  output logic [1:0]    nmis,
  output logic [AW-1:0] fail_idx
);

  logic m1;
  logic m2;

  // flag each port against its expected value
  always_comb begin
    m1       = (rv1 != exp_val(rs1, psel));
    m2       = (rv2 != exp_val(rs2, psel));
    nmis     = {1'b0, m1} + {1'b0, m2};
    fail_idx = m1 ? rs1 : (m2 ? rs2 : '0);
  end

endmodule

// File: rtl/rf_bist.sv
// Register-file BIST: write pattern, read back in
// pairs, repeat with the complement, report result.
module rf_bist
  import rf_pkg::*;
(
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic          abort,
  output logic          busy,
  output logic          done,
  output logic          pass,
  output logic [CW-1:0] err_count,
  output logic [AW-1:0] first_fail_idx,
  output logic [AW-1:0] rs1,
  output logic [AW-1:0] rs2,
  output logic [AW-1:0] rd,
  output logic          we,
  output logic [DW-1:0] indata,
  input  logic [DW-1:0] rv1,
  input  logic [DW-1:0] rv2
);

  state_e        state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic          psel_q, psel_d;
  logic          flag_q, flag_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic          pass_q, pass_d;
  logic [CW-1:0] err_q, err_d;
  logic [AW-1:0] ffi_q, ffi_d;
  logic [AW-1:0] rs1_q, rs1_d;
  logic [AW-1:0] rs2_q, rs2_d;
  logic [AW-1:0] rd_q, rd_d;
  logic          we_q, we_d;
  logic [DW-1:0] ind_q, ind_d;

  logic [1:0]    nmis;
  logic [AW-1:0] fail_idx;

  rf_bist_cmp u_cmp (
    .rs1      (rs1_q),
    .rs2      (rs2_q),
    .psel     (psel_q),
    .rv1      (rv1),
    .rv2      (rv2),
    .nmis     (nmis),
    .fail_idx (fail_idx)
  );

  // next state, counters and result capture
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    psel_d  = psel_q;
    flag_d  = flag_q;
    err_d   = err_q;
    ffi_d   = ffi_q;
    pass_d  = pass_q;
    if (abort) begin
      state_d = S_IDLE;
      pass_d  = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d = S_WRITE;
            idx_d   = '0;
            psel_d  = 1'b0;
            flag_d  = 1'b0;
            err_d   = '0;
            ffi_d   = '0;
            pass_d  = 1'b0;
          end
        end
        S_WRITE: begin
          idx_d = idx_q + 1'b1;
          if (idx_q == AW'(NREG-1)) begin
            state_d = S_READ;
            idx_d   = '0;
          end
        end
        S_READ: begin
          err_d = err_q + CW'(nmis);
          if (nmis != 2'd0 && !flag_q) begin
            flag_d = 1'b1;
            ffi_d  = fail_idx;
          end
          idx_d = idx_q + 1'b1;
          if (idx_q == AW'(NREG/2-1)) begin
            idx_d = '0;
            if (!psel_q) begin
              state_d = S_WRITE;
              psel_d  = 1'b1;
            end else begin
              state_d = S_DONE;
              pass_d  = (err_d == '0);
            end
          end
        end
        S_DONE: state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // registered RF-port and status outputs for the next state
  always_comb begin
    we_d   = (state_d == S_WRITE);
    busy_d = we_d || (state_d == S_READ);
    done_d = (state_q == S_READ) && (state_d == S_DONE);
    rd_d   = '0;
    ind_d  = '0;
    rs1_d  = '0;
    rs2_d  = '0;
    if (state_d == S_WRITE) begin
      rd_d  = idx_d;
      ind_d = pat(idx_d, psel_d);
      rs1_d = idx_d;
      rs2_d = idx_d;
    end else if (state_d == S_READ) begin
      rs1_d = {idx_d[AW-2:0], 1'b0};
      rs2_d = {idx_d[AW-2:0], 1'b1};
    end
  end

  // state and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      psel_q  <= 1'b0;
      flag_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      ffi_q   <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      rd_q    <= '0;
      we_q    <= 1'b0;
      ind_q   <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      psel_q  <= psel_d;
      flag_q  <= flag_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      ffi_q   <= ffi_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      rd_q    <= rd_d;
      we_q    <= we_d;
      ind_q   <= ind_d;
    end
  end

  assign busy           = busy_q;
  assign done           = done_q;
  assign pass           = pass_q;
  assign err_count      = err_q;
  assign first_fail_idx = ffi_q;
  assign rs1            = rs1_q;
  assign rs2            = rs2_q;
  assign rd             = rd_q;
  assign we             = we_q;
  assign indata         = ind_q;

endmodule

// File: tb/tb_rf_bist.sv
// Directed bench for rf_bist with a behavioural
// register file that can carry injected faults.
module tb_rf_bist;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic        busy;
  logic        done;
  logic        pass;
  logic [6:0]  err_count;
  logic [4:0]  first_fail_idx;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [4:0]  rd;
  logic        we;
  logic [31:0] indata;
  logic [31:0] rv1;
  logic [31:0] rv2;

  logic [31:0] mem [32];
  int          mode;
  int          n_vec;
  int          n_err;

  rf_bist dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .abort          (abort),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .err_count      (err_count),
    .first_fail_idx (first_fail_idx),
    .rs1            (rs1),
    .rs2            (rs2),
    .rd             (rd),
    .we             (we),
    .indata         (indata),
    .rv1            (rv1),
    .rv2            (rv2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (we) mem[rd] <= indata;
  end

  always_comb begin
    rv1 = (rs1 == 5'd0) ? 32'd0 : mem[rs1];
    rv2 = (rs2 == 5'd0) ? 32'd0 : mem[rs2];
    if (mode == 1 && rs1 == 5'd7) rv1 = 32'd0;
    if (mode == 1 && rs2 == 5'd7) rv2 = 32'd0;
    if (mode == 2) rv2[31] = 1'b1;
  end

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] want
  );
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // full run from IDLE; start also pulsed while busy
  task automatic run(
    output int dcyc,
    output int nwr,
    output int wr_ok
  );
    logic [31:0] wexp;
    int          ridx;
    dcyc  = -1;
    nwr   = 0;
    wr_ok = 0;
    start = 1'b1;
    for (int c = 1; c <= 150; c++) begin
      tick();
      start = (c == 39);
      if (c == 1) begin
        chk("busy_c1", 32'(busy), 32'd1);
        chk("we_c1", 32'(we), 32'd1);
        chk("rd_c1", 32'(rd), 32'd0);
        chk("wdata_c1", indata, 32'd100);
      end
      if (c == 49)
        chk("wdata_c49", indata, 32'hFFFF_FF9B);
      if (we) begin
        nwr++;
        if (c <= 32) begin
          ridx = c - 1;
          wexp = 32'(100 + ridx);
        end else begin
          ridx = c - 49;
          wexp = ~32'(100 + ridx);
        end
        if (((c >= 1 && c <= 32) || (c >= 49 && c <= 80))
            && rd == 5'(ridx) && indata == wexp)
          wr_ok++;
      end
      if (done) begin
        dcyc = c;
        break;
      end
    end
  endtask

  task automatic full(
    input string       tag,
    input logic        p_exp,
    input logic [31:0] e_exp,
    input logic [31:0] f_exp
  );
    int dcyc;
    int nwr;
    int wr_ok;
    run(dcyc, nwr, wr_ok);
    chk({tag, "_done_cyc"}, 32'(dcyc), 32'd97);
    chk({tag, "_nwr"}, 32'(nwr), 32'd64);
    chk({tag, "_wr_ok"}, 32'(wr_ok), 32'd64);
    chk({tag, "_pass"}, 32'(pass), 32'(p_exp));
    chk({tag, "_err"}, 32'(err_count), e_exp);
    chk({tag, "_ffi"}, 32'(first_fail_idx), f_exp);
    chk({tag, "_busy_done"}, 32'(busy), 32'd0);
    tick();
    chk({tag, "_done_pulse"}, 32'(done), 32'd0);
    chk({tag, "_pass_hold"}, 32'(pass), 32'(p_exp));
  endtask

  initial begin
    int ndone;
    int d1;
    int d2;
    logic saw_done;
    n_vec = 0;
    n_err = 0;
    mode  = 0;
    start = 1'b0;
    abort = 1'b0;
    rst_n = 1'b0;
    repeat (3) tick();
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_pass", 32'(pass), 32'd0);
    chk("rst_we", 32'(we), 32'd0);
    chk("rst_err", 32'(err_count), 32'd0);
    chk("rst_ffi", 32'(first_fail_idx), 32'd0);
    chk("rst_rs1", 32'(rs1), 32'd0);
    chk("rst_rs2", 32'(rs2), 32'd0);
    chk("rst_rd", 32'(rd), 32'd0);
    chk("rst_wdata", indata, 32'd0);
    rst_n = 1'b1;
    repeat (2) tick();

    full("good", 1'b1, 32'd0, 32'd0);
    mode = 1;
    full("r7stuck", 1'b0, 32'd2, 32'd7);
    mode = 2;
    full("b31stuck", 1'b0, 32'd16, 32'd1);

    // abort at edge 40 with register 7 faulty
    mode  = 1;
    start = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      tick();
      start = 1'b0;
      if (c == 39) abort = 1'b1;
    end
    abort = 1'b0;
    chk("abort_we", 32'(we), 32'd0);
    chk("abort_busy", 32'(busy), 32'd0);
    chk("abort_pass", 32'(pass), 32'd0);
    chk("abort_err", 32'(err_count), 32'd1);
    chk("abort_ffi", 32'(first_fail_idx), 32'd7);
    saw_done = 1'b0;
    for (int c = 0; c < 100; c++) begin
      tick();
      if (done) saw_done = 1'b1;
    end
    chk("abort_no_done", 32'(saw_done), 32'd0);
    chk("abort_err_hold", 32'(err_count), 32'd1);
    mode = 0;
    full("post_abort", 1'b1, 32'd0, 32'd0);

    // asynchronous reset mid-test
    start = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      tick();
      start = 1'b0;
    end
    chk("pre_rst_we", 32'(we), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_we", 32'(we), 32'd0);
    chk("arst_busy", 32'(busy), 32'd0);
    tick();
    rst_n = 1'b1;
    tick();
    chk("post_rst_we", 32'(we), 32'd0);
    chk("post_rst_busy", 32'(busy), 32'd0);
    chk("post_rst_rd", 32'(rd), 32'd0);
    chk("post_rst_wdata", indata, 32'd0);
    chk("post_rst_err", 32'(err_count), 32'd0);
    full("post_rst", 1'b1, 32'd0, 32'd0);

    // start held high: back-to-back tests
    start = 1'b1;
    ndone = 0;
    d1 = 0;
    d2 = 0;
    for (int c = 1; c <= 250; c++) begin
      tick();
      if (done) begin
        ndone++;
        if (ndone == 1) d1 = c;
        if (ndone == 2) d2 = c;
      end
    end
    start = 1'b0;
    chk("hold_first_done", 32'(d1), 32'd97);
    chk("hold_period", 32'(d2 - d1), 32'd98);
    chk("hold_ndone", 32'(ndone), 32'd2);
    repeat (110) tick();
    chk("hold_idle_busy", 32'(busy), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
